// File: rtl/aes_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : aes_word_packer
//  Brief    : Packs NB 32-bit words into one 32*NB-bit block, double-buffered
//             so the next block can assemble while the current one stalls.
//  Revision : 1.0  initial release
// ============================================================================
module aes_word_packer #(
    parameter int NB        = 4,
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [32*NB-1:0]           out_data,
    output logic                       out_partial,
    output logic [$clog2(NB+1)-1:0]    out_words
);

    localparam int c_cnt_w   = (NB > 1) ? $clog2(NB) : 1;
    localparam int c_words_w = $clog2(NB + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(NB - 1);

    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [32*NB-1:0]     asm_q, asm_d;
    logic                 out_valid_q, out_valid_d;
    logic [32*NB-1:0]     out_data_q, out_data_d;
    logic                 out_partial_q, out_partial_d;
    logic [c_words_w-1:0] out_words_q, out_words_d;

    logic                 w_closing;
    logic                 w_accept;
    int                   w_slot;
    logic [32*NB-1:0]     w_block;

    always_comb begin
        w_closing = (cnt_q == c_cnt_last) || in_last;
        // Only a block-closing word needs the output register free.
        in_ready  = !(w_closing && out_valid_q && !out_ready);
        w_accept  = in_valid && in_ready;

        w_slot  = MSW_FIRST ? (NB - 1 - int'(cnt_q)) : int'(cnt_q);
        w_block = asm_q;
        for (int s = 0; s < NB; s++) begin
            if (s == w_slot) begin
                w_block[32*s +: 32] = in_data;
            end
        end

        cnt_d         = cnt_q;
        asm_d         = asm_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_partial_d = out_partial_q;
        out_words_d   = out_words_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (w_closing) begin
                out_data_d    = w_block;
                out_words_d   = c_words_w'(cnt_q) + c_words_w'(1);
                out_partial_d = (int'(cnt_q) + 1) < NB;
                out_valid_d   = 1'b1;
                cnt_d         = '0;
                asm_d         = '0;
            end else begin
                asm_d = w_block;
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end

        // Abort wins over everything, including a same-cycle handshake.
        if (clear) begin
            cnt_d       = '0;
            asm_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            asm_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_partial_q <= 1'b0;
            out_words_q   <= '0;
        end else begin
            cnt_q         <= cnt_d;
            asm_q         <= asm_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_partial_q <= out_partial_d;
            out_words_q   <= out_words_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_partial = out_partial_q;
    assign out_words   = out_words_q;

endmodule
`default_nettype wire
